// File: rtl/rtclock_alarm.sv
// Time-of-day alarm: compares the rtclock {sec,nsec} bus against a programmed target and
// strobes o_fire once per reached target, with optional periodic re-arm and missed-period count.
module rtclock_alarm #(
  parameter int CLK_PERIOD_NS = 8,
  parameter int MISS_W        = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [47:0]       i_sec,
  input  logic [29:0]       i_nsec,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [47:0]       cfg_sec,
  input  logic [29:0]       cfg_nsec,
  input  logic [29:0]       cfg_period_nsec,
  input  logic              cfg_cancel,
  output logic              o_cfg_err,
  output logic              o_armed,
  output logic              o_fire,
  output logic [MISS_W-1:0] o_missed
);

  localparam logic [29:0] NS_PER_SEC = 30'd1_000_000_000;
  localparam logic [29:0] MIN_PERIOD = 30'(CLK_PERIOD_NS);

  typedef enum logic [1:0] {IDLE, ARMED, FIRE, CATCHUP} state_t;

  state_t              state, state_nxt;
  logic [47:0]         tgt_sec, tgt_sec_nxt;
  logic [29:0]         tgt_nsec, tgt_nsec_nxt;
  logic [29:0]         period, period_nxt;
  logic [MISS_W-1:0]   miss, miss_nxt;
  logic                cfg_err_p1, cfg_err_nxt;
  logic                fire_p1, fire_nxt;
  logic                cfg_take, cfg_bad;
  logic [47:0]         adv_sec;
  logic [29:0]         adv_nsec;

  // Target + period with nanosecond-to-second carry; seconds wrap modulo 2^48.
  function automatic logic [77:0] add_period(input logic [47:0] sec, input logic [29:0] nsec,
                                             input logic [29:0] per);
    logic [30:0] s;
    s = {1'b0, nsec} + {1'b0, per};
    if (s >= {1'b0, NS_PER_SEC})
      return {sec + 48'd1, 30'(s - {1'b0, NS_PER_SEC})};
    return {sec, s[29:0]};
  endfunction

  function automatic logic reached(input logic [47:0] sec, input logic [29:0] nsec,
                                   input logic [47:0] t_sec, input logic [29:0] t_nsec);
    return (sec > t_sec) || ((sec == t_sec) && (nsec >= t_nsec));
  endfunction

  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign cfg_ready = (state == IDLE) || (state == ARMED);
  assign cfg_take  = cfg_valid && cfg_ready;
  assign cfg_bad   = (cfg_nsec >= NS_PER_SEC) ||
                     ((cfg_period_nsec != 30'd0) &&
                      ((cfg_period_nsec < MIN_PERIOD) || (cfg_period_nsec >= NS_PER_SEC)));
  assign {adv_sec, adv_nsec} = add_period(tgt_sec, tgt_nsec, period);

  // Stage p0: compare and next-state decode on the current time bus
  always_comb begin
    state_nxt    = state;
    tgt_sec_nxt  = tgt_sec;
    tgt_nsec_nxt = tgt_nsec;
    period_nxt   = period;
    miss_nxt     = miss;
    cfg_err_nxt  = 1'b0;
    fire_nxt     = 1'b0;
    if (cfg_cancel) begin
      state_nxt = IDLE;
    end else if (cfg_take && !cfg_bad) begin
      tgt_sec_nxt  = cfg_sec;
      tgt_nsec_nxt = cfg_nsec;
      period_nxt   = cfg_period_nsec;
      miss_nxt     = '0;
      state_nxt    = ARMED;
    end else begin
      cfg_err_nxt = cfg_take;
      case (state)
        ARMED: begin
          if (reached(i_sec, i_nsec, tgt_sec, tgt_nsec)) begin
            state_nxt = FIRE;
            fire_nxt  = 1'b1;
          end
        end
        FIRE: begin
          if (period == 30'd0) begin
            state_nxt = IDLE;
          end else begin
            tgt_sec_nxt  = adv_sec;
            tgt_nsec_nxt = adv_nsec;
            state_nxt    = reached(i_sec, i_nsec, adv_sec, adv_nsec) ? CATCHUP : ARMED;
          end
        end
        CATCHUP: begin
          // Skip stale targets without strobing; stop on the first one still in the future.
          tgt_sec_nxt  = adv_sec;
          tgt_nsec_nxt = adv_nsec;
          if (reached(i_sec, i_nsec, adv_sec, adv_nsec)) miss_nxt = sat_inc(miss);
          else state_nxt = ARMED;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Stage p1: registered state, target and strobes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      tgt_sec    <= '0;
      tgt_nsec   <= '0;
      period     <= '0;
      miss       <= '0;
      cfg_err_p1 <= 1'b0;
      fire_p1    <= 1'b0;
    end else begin
      state      <= state_nxt;
      tgt_sec    <= tgt_sec_nxt;
      tgt_nsec   <= tgt_nsec_nxt;
      period     <= period_nxt;
      miss       <= miss_nxt;
      cfg_err_p1 <= cfg_err_nxt;
      fire_p1    <= fire_nxt;
    end
  end

  assign o_cfg_err = cfg_err_p1;
  assign o_fire    = fire_p1;
  assign o_armed   = (state != IDLE);
  assign o_missed  = miss;

endmodule

// File: tb/tb_rtclock_alarm.sv
// Directed bench for rtclock_alarm: time bus is driven by hand, expected values are hand-computed.
module tb_rtclock_alarm;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [47:0] i_sec = '0;
  logic [29:0] i_nsec = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [47:0] cfg_sec = '0;
  logic [29:0] cfg_nsec = '0;
  logic [29:0] cfg_period_nsec = '0;
  logic        cfg_cancel = 1'b0;
  logic        o_cfg_err;
  logic        o_armed;
  logic        o_fire;
  logic [15:0] o_missed;

  int total = 0;
  int bad = 0;

  rtclock_alarm #(.CLK_PERIOD_NS(8), .MISS_W(16)) dut (
    .clk(clk), .resetn(resetn), .i_sec(i_sec), .i_nsec(i_nsec),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sec(cfg_sec), .cfg_nsec(cfg_nsec),
    .cfg_period_nsec(cfg_period_nsec), .cfg_cancel(cfg_cancel), .o_cfg_err(o_cfg_err),
    .o_armed(o_armed), .o_fire(o_fire), .o_missed(o_missed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settime(input logic [47:0] s, input logic [29:0] ns);
    i_sec  = s;
    i_nsec = ns;
  endtask

  task automatic cfg(input logic [47:0] s, input logic [29:0] ns, input logic [29:0] per);
    cfg_valid       = 1'b1;
    cfg_sec         = s;
    cfg_nsec        = ns;
    cfg_period_nsec = per;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic cancel();
    cfg_cancel = 1'b1;
    tick();
    cfg_cancel = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fires;

    // reset values
    tick(); tick();
    chk("rst_fire", o_fire, 0);
    chk("rst_armed", o_armed, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_err", o_cfg_err, 0);
    chk("rst_missed", o_missed, 0);
    resetn = 1'b1;
    tick();

    // one-shot at 3.0 s
    settime(2, 999_999_992);
    cfg(3, 0, 0);
    chk("os_armed", o_armed, 1);
    tick();
    chk("os_early", o_fire, 0);
    settime(3, 0);
    tick();
    chk("os_fire", o_fire, 1);
    chk("os_ready_fire", cfg_ready, 0);
    tick();
    chk("os_fire_off", o_fire, 0);
    chk("os_disarm", o_armed, 0);
    chk("os_ready", cfg_ready, 1);
    tick();
    chk("os_once", o_fire, 0);

    // periodic 8 ns with second carry
    settime(1, 999_999_990);
    cfg(1, 999_999_996, 8);
    tick();
    chk("per_early", o_fire, 0);
    settime(1, 999_999_996);
    tick();
    chk("per_fire0", o_fire, 1);
    tick();
    chk("per_gap", o_fire, 0);
    chk("per_armed", o_armed, 1);
    settime(2, 3);
    tick();
    chk("per_before1", o_fire, 0);
    settime(2, 4);
    tick();
    chk("per_fire1", o_fire, 1);
    tick();
    settime(2, 11);
    tick();
    chk("per_before2", o_fire, 0);
    settime(2, 12);
    tick();
    chk("per_fire2", o_fire, 1);
    tick();
    chk("per_missed", o_missed, 0);
    cancel();
    chk("per_cancel", o_armed, 0);

    // rejected configurations
    cfg(0, 30'd1_000_000_000, 0);
    chk("bad_nsec_err", o_cfg_err, 1);
    chk("bad_nsec_armed", o_armed, 0);
    tick();
    chk("err_pulse", o_cfg_err, 0);
    settime(0, 0);
    cfg(50, 0, 0);
    chk("arm50", o_armed, 1);
    cfg(60, 0, 4);
    chk("bad_per_err", o_cfg_err, 1);
    chk("bad_per_armed", o_armed, 1);
    cfg(60, 0, 30'd1_000_000_000);
    chk("big_per_err", o_cfg_err, 1);
    settime(50, 0);
    tick();
    chk("tgt_kept", o_fire, 1);
    tick();
    chk("tgt_kept_idle", o_armed, 0);

    // cancel beats a simultaneous config, one cycle before the target
    settime(19, 999_999_992);
    cfg(20, 0, 0);
    cfg_valid = 1'b1; cfg_sec = 30; cfg_nsec = 0; cfg_period_nsec = 0;
    cfg_cancel = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_cancel = 1'b0;
    chk("cxl_armed", o_armed, 0);
    chk("cxl_err", o_cfg_err, 0);
    settime(20, 0);
    tick();
    chk("cxl_nofire", o_fire, 0);
    tick();
    chk("cxl_nofire2", o_fire, 0);

    // past target, one-shot
    settime(10, 0);
    cfg(5, 0, 0);
    chk("past_os_armed", o_fire, 0);
    tick();
    chk("past_os_fire", o_fire, 1);
    tick();
    chk("past_os_single", o_fire, 0);
    chk("past_os_idle", o_armed, 0);

    // past target, periodic 1 ms
    cfg(5, 0, 1_000_000);
    tick();
    chk("past_per_fire", o_fire, 1);
    tick();
    chk("past_per_catchup_ready", cfg_ready, 0);
    chk("past_per_catchup_armed", o_armed, 1);
    n = 0;
    fires = 0;
    while (!cfg_ready && n < 6000) begin
      tick();
      if (o_fire) fires++;
      n++;
    end
    chk("catchup_done", cfg_ready, 1);
    chk("catchup_fires", fires, 0);
    chk("catchup_missed", o_missed, 4999);
    tick(); tick(); tick();
    chk("catchup_quiet", o_fire, 0);
    settime(10, 1_000_000);
    tick();
    chk("catchup_next_fire", o_fire, 1);
    tick();
    cancel();

    // reset during FIRE
    settime(0, 0);
    cfg(0, 8, 0);
    settime(0, 8);
    tick();
    chk("rf_fire", o_fire, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rf_fire_drop", o_fire, 0);
    chk("rf_armed_drop", o_armed, 0);
    tick();
    resetn = 1'b1;
    settime(1, 0);
    cfg(2, 0, 0);
    chk("rf_rearm", o_armed, 1);
    settime(2, 0);
    tick();
    chk("rf_refire", o_fire, 1);
    tick();
    chk("rf_idle", o_armed, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
